// File: rtl/clock_edge_meter_pkg.sv
// Shared types and constants for the clock edge meter: FSM encoding and the
// default timeout that matches the clock divider's default modulo.
package clock_edge_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALLED = 2'd2
  } meter_state_t;

  // The divider toggles every MODULO cycles, so a full period is twice that.
  localparam int unsigned DIV_DEFAULT_MODULO = 300000;
  localparam int unsigned DEFAULT_MAX_PERIOD = 2 * DIV_DEFAULT_MODULO;

  function automatic int cnt_width(input int max_period);
    return $clog2(max_period + 1);
  endfunction

endpackage

// File: rtl/clock_edge_meter_if.sv
// Result bundle of the clock edge meter: synchronized level, edge strobes,
// measured period and stall flag.
interface clock_edge_meter_if
  import clock_edge_meter_pkg::*;
#(
  parameter int CNT_W = cnt_width(DEFAULT_MAX_PERIOD)
);

  logic             level;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stalled;

  modport master (
    output level,
    output rise_pulse,
    output fall_pulse,
    output period,
    output period_valid,
    output stalled
  );

  modport slave (
    input level,
    input rise_pulse,
    input fall_pulse,
    input period,
    input period_valid,
    input stalled
  );

endinterface

// File: rtl/clock_edge_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level followed by registered
// one-cycle rise/fall strobes. Usable for buttons and other async inputs.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_edge_detect: SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      level_prev <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
      // Strobes compare the settled level against its one-cycle-old copy.
      level_prev <= sync_q[SYNC_STAGES-1];
      rise       <= sync_q[SYNC_STAGES-1] & ~level_prev;
      fall       <= ~sync_q[SYNC_STAGES-1] & level_prev;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_edge_meter.sv
// Brings a slow asynchronous clock into the clk domain, emits edge strobes,
// measures the rising-to-rising period and flags a stalled source.
module clock_edge_meter
  import clock_edge_meter_pkg::*;
#(
  parameter  int SYNC_STAGES = 2,
  parameter  int MAX_PERIOD  = DEFAULT_MAX_PERIOD,
  localparam int CNT_W       = cnt_width(MAX_PERIOD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_in,
  clock_edge_meter_if.master    mon
);

  if (MAX_PERIOD < 4) begin : g_bad_max
    $error("clock_edge_meter: MAX_PERIOD must be at least 4");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic level;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (clk_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             stalled_q, stalled_d;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] count_plus1;

  // count_plus1 is only consumed in MEASURE, where count stays below MAX_CNT.
  assign count_plus1 = count_q + ONE;
  assign count_inc   = (count_q == MAX_CNT) ? count_q : count_plus1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_inc;
    period_d       = period_q;
    period_valid_d = 1'b0;
    stalled_d      = stalled_q;

    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (rise) begin
          state_d = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        // A rise in the timeout cycle still publishes MAX_PERIOD.
        if (rise) begin
          period_d       = count_plus1;
          period_valid_d = 1'b1;
          count_d        = '0;
        end else if (count_plus1 == MAX_CNT) begin
          state_d   = ST_STALLED;
          stalled_d = 1'b1;
        end
      end

      ST_STALLED: begin
        // The interval spanning a stall is meaningless, so it is dropped.
        if (rise) begin
          state_d   = ST_MEASURE;
          stalled_d = 1'b0;
          count_d   = '0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        count_d   = '0;
        stalled_d = 1'b0;
      end
    endcase
  end

  assign mon.level        = level;
  assign mon.rise_pulse   = rise;
  assign mon.fall_pulse   = fall;
  assign mon.period       = period_q;
  assign mon.period_valid = period_valid_q;
  assign mon.stalled      = stalled_q;

endmodule

// File: tb/tb_clock_edge_meter.sv
// Directed bench for clock_edge_meter with a queue-based period scoreboard.
module tb_clock_edge_meter;
  import clock_edge_meter_pkg::*;

  localparam int MAXP  = 16;
  localparam int CNT_W = cnt_width(MAXP);

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic clk_in = 1'b0;

  clock_edge_meter_if #(.CNT_W(CNT_W)) mon_if ();

  clock_edge_meter #(
    .SYNC_STAGES (2),
    .MAX_PERIOD  (MAXP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_in (clk_in),
    .mon    (mon_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_v;
  int cyc = 0;
  int last_rise_cyc = 0;
  int exp_spacing = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  bit stall_seen = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: pops an expected period for every period_valid strobe.
  always @(negedge clk) begin
    if (reset) begin
      if (mon_if.period_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL period_valid_unexpected: got strobe with period=%0d, required no strobe",
                   mon_if.period);
        end else begin
          exp_v = exp_q.pop_front();
          if (mon_if.period !== exp_v[CNT_W-1:0]) begin
            errors++;
            $display("FAIL period_value: got %0d, required %0d", mon_if.period, exp_v);
          end
        end
      end
      if (mon_if.rise_pulse) begin
        rise_cnt++;
        last_rise_cyc = cyc;
      end
      if (mon_if.fall_pulse) begin
        fall_cnt++;
        if (exp_spacing != 0) begin
          checks++;
          if (cyc - last_rise_cyc != exp_spacing) begin
            errors++;
            $display("FAIL rise_fall_spacing: got %0d, required %0d",
                     cyc - last_rise_cyc, exp_spacing);
          end
        end
      end
      if (mon_if.stalled) stall_seen = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_level"},   32'(mon_if.level),        0);
    check({tag, "_rise"},    32'(mon_if.rise_pulse),   0);
    check({tag, "_fall"},    32'(mon_if.fall_pulse),   0);
    check({tag, "_period"},  32'(mon_if.period),       0);
    check({tag, "_pvalid"},  32'(mon_if.period_valid), 0);
    check({tag, "_stalled"}, 32'(mon_if.stalled),      0);
  endtask

  task automatic do_reset();
    clk_in = 1'b0;
    reset  = 1'b0;
    #1;
    step(2);
    check_cleared("reset");
    reset = 1'b1;
    step(2);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, f0;

    // Edge latency and single-cycle strobe
    do_reset();
    clk_in = 1'b1;
    step(1);
    check("t1_e1_level", 32'(mon_if.level), 0);
    check("t1_e1_rise",  32'(mon_if.rise_pulse), 0);
    step(1);
    check("t1_e2_level", 32'(mon_if.level), 1);
    check("t1_e2_rise",  32'(mon_if.rise_pulse), 0);
    step(1);
    check("t1_e3_rise",  32'(mon_if.rise_pulse), 1);
    step(1);
    check("t1_e4_rise",  32'(mon_if.rise_pulse), 0);
    clk_in = 1'b0;
    step(6);

    // Square wave with a 10-cycle period
    do_reset();
    exp_spacing = 5;
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int i = 0; i < 4; i++) begin
      clk_in = 1'b1;
      if (i > 0) exp_q.push_back(10);
      step(5);
      check("t2_stalled_hi", 32'(mon_if.stalled), 0);
      clk_in = 1'b0;
      step(5);
    end
    check("t2_stalled_end", 32'(mon_if.stalled), 0);
    check("t2_rise_count", 32'(rise_cnt - r0), 4);
    check("t2_fall_count", 32'(fall_cnt - f0), 4);
    check("t2_queue_drained", 32'(exp_q.size()), 0);
    exp_spacing = 0;

    // Stall, recovery without a report, then a 12-cycle period
    do_reset();
    clk_in = 1'b1;
    step(5);
    clk_in = 1'b0;
    step(5);
    clk_in = 1'b1;
    exp_q.push_back(10);
    step(10);
    check("t3_not_yet_stalled", 32'(mon_if.stalled), 0);
    step(14);
    check("t3_stalled", 32'(mon_if.stalled), 1);
    clk_in = 1'b0;
    step(4);
    check("t3_stalled_after_fall", 32'(mon_if.stalled), 1);
    clk_in = 1'b1;
    step(5);
    check("t3_stall_cleared", 32'(mon_if.stalled), 0);
    check("t3_period_held", 32'(mon_if.period), 10);
    clk_in = 1'b0;
    step(7);
    clk_in = 1'b1;
    exp_q.push_back(12);
    step(6);
    check("t3_queue_drained", 32'(exp_q.size()), 0);

    // Period exactly at the timeout: rise wins over stall
    do_reset();
    stall_seen = 1'b0;
    clk_in = 1'b1;
    step(8);
    clk_in = 1'b0;
    step(8);
    clk_in = 1'b1;
    exp_q.push_back(16);
    step(8);
    clk_in = 1'b0;
    step(8);
    clk_in = 1'b1;
    exp_q.push_back(16);
    step(6);
    check("t4_stall_never", 32'(stall_seen), 0);
    check("t4_stalled", 32'(mon_if.stalled), 0);
    check("t4_queue_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of a measurement
    do_reset();
    clk_in = 1'b1;
    step(8);
    reset = 1'b0;
    #1;
    check_cleared("t5_async");
    clk_in = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    clk_in = 1'b1;
    step(4);
    clk_in = 1'b0;
    step(4);
    clk_in = 1'b1;
    exp_q.push_back(8);
    step(6);
    check("t5_queue_drained", 32'(exp_q.size()), 0);

    // Divide-by-8 source (toggle every 4 cycles) from the same clk
    do_reset();
    exp_spacing = 4;
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int i = 0; i < 6; i++) begin
      clk_in = 1'b1;
      if (i > 0) exp_q.push_back(8);
      step(4);
      clk_in = 1'b0;
      step(4);
    end
    step(4);
    check("t6_rise_count", 32'(rise_cnt - r0), 6);
    check("t6_fall_count", 32'(fall_cnt - f0), 6);
    check("t6_queue_drained", 32'(exp_q.size()), 0);
    exp_spacing = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
